// File: rtl/npu_bus_decoder.sv
// Single-master, two-slave address decoder with an in-order response router.
// Unmapped requests are answered internally with an error response.
module npu_bus_decoder #(
  parameter logic [31:0] S0_START = 32'h00000000,
  parameter logic [31:0] S0_END   = 32'h02004000,
  parameter logic [31:0] S1_START = 32'h10000000,
  parameter logic [31:0] S1_END   = 32'h20000000,
  parameter int          OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req_valid,
  output logic        m_req_ready,
  input  logic [31:0] m_req_addr,
  input  logic        m_req_we,
  input  logic [31:0] m_req_wdata,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [31:0] m_rsp_rdata,
  output logic        m_rsp_err,
  output logic        s0_req_valid,
  input  logic        s0_req_ready,
  output logic [31:0] s0_req_addr,
  output logic        s0_req_we,
  output logic [31:0] s0_req_wdata,
  input  logic        s0_rsp_valid,
  output logic        s0_rsp_ready,
  input  logic [31:0] s0_rsp_rdata,
  output logic        s1_req_valid,
  input  logic        s1_req_ready,
  output logic [31:0] s1_req_addr,
  output logic        s1_req_we,
  output logic [31:0] s1_req_wdata,
  output logic [2:0]  s1_req_region,
  input  logic        s1_rsp_valid,
  output logic        s1_rsp_ready,
  input  logic [31:0] s1_rsp_rdata
);
  localparam int PW = $clog2(OT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OT_DEPTH);

  typedef enum logic [1:0] {DST_S0 = 2'd0, DST_S1 = 2'd1, DST_ERR = 2'd2} dest_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  region;
    logic        dest;
  } slot_t;

  logic [31:0] off0, off1;
  dest_t       dest_d;
  logic [2:0]  region_d;

  assign off0 = m_req_addr - S0_START;
  assign off1 = m_req_addr - S1_START;

  // Range test via the offset so wrap-around stays unsigned mod 2^32
  always_comb begin
    dest_d = DST_ERR;
    if (off0 < (S0_END - S0_START))      dest_d = DST_S0;
    else if (off1 < (S1_END - S1_START)) dest_d = DST_S1;
  end

  always_comb begin
    region_d = 3'd7;
    if      (off1 < 32'h3100) region_d = 3'd0;
    else if (off1 < 32'h6200) region_d = 3'd1;
    else if (off1 < 32'h6280) region_d = 3'd2;
    else if (off1 < 32'h8280) region_d = 3'd3;
    else if (off1 < 32'h8300) region_d = 3'd4;
    else if (off1 < 32'h8310) region_d = 3'd5;
  end

  logic        slot_vld;
  slot_t       slot_q;
  logic        drain, accept, pop;
  logic [PW:0] cnt;

  assign drain       = slot_vld && (slot_q.dest ? s1_req_ready : s0_req_ready);
  assign m_req_ready = !rst && (cnt < DEPTH_C) && (!slot_vld || drain);
  assign accept      = m_req_valid && m_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= 1'b0;
      slot_q   <= '0;
    end else if (accept && dest_d != DST_ERR) begin
      slot_vld      <= 1'b1;
      slot_q.addr   <= (dest_d == DST_S1) ? off1 : off0;
      slot_q.we     <= m_req_we;
      slot_q.wdata  <= m_req_wdata;
      slot_q.region <= region_d;
      slot_q.dest   <= dest_d[0];
    end else if (drain) begin
      slot_vld <= 1'b0;
    end
  end

  // Payload is gated so an idle port shows all zeros
  assign s0_req_valid  = slot_vld && !slot_q.dest;
  assign s1_req_valid  = slot_vld &&  slot_q.dest;
  assign s0_req_addr   = s0_req_valid ? slot_q.addr  : '0;
  assign s0_req_we     = s0_req_valid && slot_q.we;
  assign s0_req_wdata  = s0_req_valid ? slot_q.wdata : '0;
  assign s1_req_addr   = s1_req_valid ? slot_q.addr  : '0;
  assign s1_req_we     = s1_req_valid && slot_q.we;
  assign s1_req_wdata  = s1_req_valid ? slot_q.wdata : '0;
  assign s1_req_region = s1_req_valid ? slot_q.region : '0;

  logic [1:0]    trk [OT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  dest_t         head;

  assign head = dest_t'(trk[rd_ptr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < OT_DEPTH; i++) trk[i] <= 2'd0;
    end else begin
      if (accept) begin
        trk[wr_ptr] <= dest_d;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    m_rsp_valid  = 1'b0;
    m_rsp_rdata  = '0;
    m_rsp_err    = 1'b0;
    s0_rsp_ready = 1'b0;
    s1_rsp_ready = 1'b0;
    if (cnt != '0) begin
      case (head)
        DST_S0: begin
          m_rsp_valid  = s0_rsp_valid;
          m_rsp_rdata  = s0_rsp_rdata;
          s0_rsp_ready = m_rsp_ready;
        end
        DST_S1: begin
          m_rsp_valid  = s1_rsp_valid;
          m_rsp_rdata  = s1_rsp_rdata;
          s1_rsp_ready = m_rsp_ready;
        end
        default: begin
          m_rsp_valid = 1'b1;
          m_rsp_err   = 1'b1;
        end
      endcase
    end
  end

  assign pop = m_rsp_valid && m_rsp_ready;
endmodule

// File: tb/tb_npu_bus_decoder.sv
// Directed bench for npu_bus_decoder: decode, regions, ordering, backpressure, reset.
module tb_npu_bus_decoder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m_req_valid = 0, m_req_ready, m_req_we = 0;
  logic [31:0] m_req_addr = 0, m_req_wdata = 0;
  logic        m_rsp_valid, m_rsp_ready = 0, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic        s0_req_valid, s0_req_ready = 0, s0_req_we, s0_rsp_valid = 0, s0_rsp_ready;
  logic [31:0] s0_req_addr, s0_req_wdata, s0_rsp_rdata = 0;
  logic        s1_req_valid, s1_req_ready = 0, s1_req_we, s1_rsp_valid = 0, s1_rsp_ready;
  logic [31:0] s1_req_addr, s1_req_wdata, s1_rsp_rdata = 0;
  logic [2:0]  s1_req_region;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  npu_bus_decoder dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_err(m_rsp_err),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_addr(s0_req_addr),
    .s0_req_we(s0_req_we), .s0_req_wdata(s0_req_wdata),
    .s0_rsp_valid(s0_rsp_valid), .s0_rsp_ready(s0_rsp_ready), .s0_rsp_rdata(s0_rsp_rdata),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_addr(s1_req_addr),
    .s1_req_we(s1_req_we), .s1_req_wdata(s1_req_wdata), .s1_req_region(s1_req_region),
    .s1_rsp_valid(s1_rsp_valid), .s1_rsp_ready(s1_rsp_ready), .s1_rsp_rdata(s1_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge and hold it until accepted (bounded)
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit ok = 0;
    @(negedge clk);
    m_req_valid = 1; m_req_addr = a; m_req_we = w; m_req_wdata = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      if (m_req_ready) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
    #1 m_req_valid = 0;
  endtask

  task automatic rsp(input int s, input logic [31:0] d, input string tag);
    @(negedge clk);
    m_rsp_ready = 1;
    if (s == 0) begin s0_rsp_valid = 1; s0_rsp_rdata = d; end
    else        begin s1_rsp_valid = 1; s1_rsp_rdata = d; end
    #1;
    chk({tag, "_valid"}, m_rsp_valid, 1);
    chk({tag, "_rdata"}, m_rsp_rdata, d);
    chk({tag, "_err"}, m_rsp_err, 0);
    chk({tag, "_sready"}, (s == 0) ? s0_rsp_ready : s1_rsp_ready, 1);
    @(posedge clk);
    #1 s0_rsp_valid = 0; s1_rsp_valid = 0; m_rsp_ready = 0;
  endtask

  task automatic errt(input logic [31:0] a, input string tag);
    send(a, 0, 32'h0);
    @(negedge clk);
    chk({tag, "_s0v"}, s0_req_valid, 0);
    chk({tag, "_s1v"}, s1_req_valid, 0);
    chk({tag, "_valid"}, m_rsp_valid, 1);
    chk({tag, "_err"}, m_rsp_err, 1);
    chk({tag, "_rdata"}, m_rsp_rdata, 0);
    m_rsp_ready = 1;
    @(posedge clk);
    #1 m_rsp_ready = 0;
    @(negedge clk);
    chk({tag, "_popped"}, m_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_s0v", s0_req_valid, 0);
    chk("rst_s1v", s1_req_valid, 0);
    chk("rst_mrspv", m_rsp_valid, 0);
    chk("rst_err", m_rsp_err, 0);
    chk("rst_s1addr", s1_req_addr, 0);
    chk("rst_region", s1_req_region, 0);
    rst = 0;
    #1 chk("rst_ready", m_req_ready, 1);
    s0_req_ready = 1; s1_req_ready = 1;

    // basic read to slave 0
    send(32'h10, 0, 0);
    @(negedge clk);
    chk("t1_s0v", s0_req_valid, 1);
    chk("t1_s0addr", s0_req_addr, 32'h10);
    chk("t1_s0we", s0_req_we, 0);
    chk("t1_s1v", s1_req_valid, 0);
    @(negedge clk);
    chk("t1_drained", s0_req_valid, 0);
    chk("t1_norsp", m_rsp_valid, 0);
    @(negedge clk);
    rsp(0, 32'hDEADBEEF, "t1_rsp");

    // write to slave 1 with request stall; region checks
    s1_req_ready = 0;
    send(32'h10006284, 1, 32'hCAFE0001);
    @(negedge clk);
    chk("t2_s1v", s1_req_valid, 1);
    chk("t2_addr", s1_req_addr, 32'h6284);
    chk("t2_region", s1_req_region, 3);
    chk("t2_we", s1_req_we, 1);
    chk("t2_wdata", s1_req_wdata, 32'hCAFE0001);
    @(negedge clk);
    chk("t2_hold_v", s1_req_valid, 1);
    chk("t2_hold_addr", s1_req_addr, 32'h6284);
    s1_req_ready = 1;
    @(negedge clk);
    chk("t2_drained", s1_req_valid, 0);
    rsp(1, 32'h0, "t2_rsp");
    send(32'h1000830C, 0, 0);
    @(negedge clk);
    chk("r5_region", s1_req_region, 5);
    chk("r5_addr", s1_req_addr, 32'h830C);
    rsp(1, 32'h5, "r5_rsp");
    send(32'h10008310, 0, 0);
    @(negedge clk);
    chk("r7_region", s1_req_region, 7);
    chk("r7_s1v", s1_req_valid, 1);
    rsp(1, 32'h7, "r7_rsp");
    send(32'h1FFFFFFC, 0, 0);
    @(negedge clk);
    chk("s1top_addr", s1_req_addr, 32'h0FFFFFFC);
    chk("s1top_region", s1_req_region, 7);
    rsp(1, 32'h8, "s1top_rsp");
    send(32'h02003FFC, 0, 0);
    @(negedge clk);
    chk("s0top_v", s0_req_valid, 1);
    chk("s0top_addr", s0_req_addr, 32'h02003FFC);
    rsp(0, 32'h9, "s0top_rsp");

    // unmapped addresses
    errt(32'h05000000, "err_mid");
    errt(32'h02004000, "err_s0end");
    errt(32'h0FFFFFFF, "err_below_s1");

    // in-order return: s1 then s0, s0 answers first
    send(32'h10000000, 0, 0);
    send(32'h20, 0, 0);
    @(negedge clk);
    s0_rsp_valid = 1; s0_rsp_rdata = 32'hA0; m_rsp_ready = 1;
    #1;
    chk("ord_s0hold", s0_rsp_ready, 0);
    chk("ord_noval", m_rsp_valid, 0);
    @(negedge clk);
    chk("ord_s0hold2", s0_rsp_ready, 0);
    s1_rsp_valid = 1; s1_rsp_rdata = 32'hB1;
    #1;
    chk("ord_v1", m_rsp_valid, 1);
    chk("ord_d1", m_rsp_rdata, 32'hB1);
    chk("ord_s1rdy", s1_rsp_ready, 1);
    chk("ord_s0rdy0", s0_rsp_ready, 0);
    @(negedge clk);
    s1_rsp_valid = 0;
    #1;
    chk("ord_d0", m_rsp_rdata, 32'hA0);
    chk("ord_s0rdy", s0_rsp_ready, 1);
    @(negedge clk);
    s0_rsp_valid = 0; m_rsp_ready = 0;
    #1 chk("ord_empty", m_rsp_valid, 0);

    // outstanding limit
    send(32'h100, 0, 0);
    send(32'h10000004, 0, 0);
    send(32'h200, 0, 0);
    send(32'h300, 0, 0);
    @(negedge clk);
    m_req_valid = 1; m_req_addr = 32'h400; m_req_we = 0;
    #1 chk("full_ready0", m_req_ready, 0);
    @(negedge clk);
    chk("full_ready0b", m_req_ready, 0);
    s0_rsp_valid = 1; s0_rsp_rdata = 32'h11; m_rsp_ready = 1;
    #1;
    chk("full_pop_d", m_rsp_rdata, 32'h11);
    chk("full_pop_rdy", m_req_ready, 0);
    @(negedge clk);
    s0_rsp_valid = 0; s1_rsp_valid = 1; s1_rsp_rdata = 32'h22;
    #1;
    chk("full_cnt3_rdy", m_req_ready, 1);
    chk("full_s1_d", m_rsp_rdata, 32'h22);
    chk("full_s1_rdy", s1_rsp_ready, 1);
    @(negedge clk);
    s1_rsp_valid = 0; m_req_addr = 32'h500;
    #1;
    chk("full_s0v", s0_req_valid, 1);
    chk("full_s0addr", s0_req_addr, 32'h400);
    chk("full_still3", m_req_ready, 1);
    @(negedge clk);
    m_req_addr = 32'h600;
    #1;
    chk("full_again", m_req_ready, 0);
    chk("full_s0addr2", s0_req_addr, 32'h500);
    m_req_valid = 0; m_rsp_ready = 0;
    rsp(0, 32'h33, "full_r1");
    rsp(0, 32'h44, "full_r2");
    rsp(0, 32'h55, "full_r3");
    rsp(0, 32'h66, "full_r4");
    @(negedge clk);
    chk("full_empty", m_rsp_valid, 0);

    // reset with two outstanding
    send(32'h40, 0, 0);
    s1_req_ready = 0;
    send(32'h10000020, 0, 0);
    @(negedge clk);
    chk("mrst_pre_s1v", s1_req_valid, 1);
    s0_rsp_valid = 1; s0_rsp_rdata = 32'h99; rst = 1;
    #1;
    chk("mrst_s1v", s1_req_valid, 0);
    chk("mrst_s1addr", s1_req_addr, 0);
    chk("mrst_mrspv", m_rsp_valid, 0);
    chk("mrst_s0rdy", s0_rsp_ready, 0);
    @(negedge clk);
    rst = 0; s0_rsp_valid = 0; s1_req_ready = 1;
    #1;
    chk("mrst_after_v", m_rsp_valid, 0);
    chk("mrst_after_rdy", m_req_ready, 1);
    send(32'h10000040, 0, 0);
    @(negedge clk);
    chk("mrst_new_s1v", s1_req_valid, 1);
    chk("mrst_new_addr", s1_req_addr, 32'h40);
    chk("mrst_new_region", s1_req_region, 0);
    rsp(1, 32'h77, "mrst_rsp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
